ext_irq_controller: RTL and testbench
=====================================

// Module: ext_irq_controller
// PURPOSE
//  Multi-channel external interrupt controller feeding processor_arm's single ExtIRQ/ExtIAck pair.
//  Synchronises N_IRQ async sources and latches edge- or level-mode requests with per-channel masking.
//  Presents the highest-priority pending channel (lowest index wins) as ExtIRQ plus irq_id.
//  Holds the request until the core acknowledges it, then clears that channel.
// PARAMETERS
//  N_IRQ       8                 number of interrupt channels (2..32)
//  ID_W        $clog2(N_IRQ)     width of irq_id
//  SYNC_STAGES 2                 flip-flop stages in each input synchroniser (>=2)
// PORTS
//  CLOCK_50    in   1      system clock; all state updates on posedge
//  reset       in   1      asynchronous, active-high reset
//  irq_in      in   N_IRQ  raw async interrupt sources
//  edge_mode   in   N_IRQ  per channel: 1 = rising-edge latched, 0 = level-sensitive (quasi-static)
//  mask_we     in   1      write strobe for mask register
//  mask_wdata  in   N_IRQ  new mask value; bit=1 enables the channel
//  ExtIRQ      out  1      interrupt request to core
//  irq_id      out  ID_W   channel being requested; valid while ExtIRQ=1
//  ExtIAck     in   1      core acknowledge; sampled only while ExtIRQ=1
//  irq_ovf     out  N_IRQ  sticky per-channel overflow: edge lost while already pending
// BEHAVIOUR
//  Reset values: ExtIRQ=0, irq_id=0, irq_ovf=0, pending=0, mask=0 (all disabled), sync chains=0, FSM=IDLE.
//  Sync: each irq_in bit passes through SYNC_STAGES flops; s = last stage, s_d = s delayed one cycle.
//  Pending, edge channel: set when s & ~s_d; cleared on ack of that id.
//    - Set and clear in the same cycle: set wins (new event not lost).
//  Pending, level channel: pending = s. Ack has no effect; the source must deassert.
//  Overflow: edge-set while pending[ch] is already 1 and not being cleared -> irq_ovf[ch]<=1.
//    - irq_ovf[ch] is cleared on ack of ch.
//  Mask: mask <= mask_wdata on mask_we. It gates only the arbitration, never pending capture.
//  Arbitration: req = pending & mask; winner = lowest set index; any = |req.
//  FSM (state register in CLOCK_50 domain):
//    IDLE: any=1 -> REQ; latch irq_id <= winner.
//    REQ: ExtIRQ=1, irq_id stable.
//      - ExtIAck=1 -> clear pending[irq_id] (edge) and irq_ovf[irq_id]; go to GAP.
//      - Request is never retracted, even if masked or deasserted meanwhile.
//    GAP: ExtIRQ=0 for exactly one cycle -> IDLE. Guarantees a falling edge between requests.
//  ExtIRQ is a registered decode of state==REQ. irq_id holds its last value outside REQ.
//  Latency: irq_in rising, setup met at edge k, SYNC_STAGES=2:
//    pending=1 after edge k+2, FSM=REQ after k+3, so ExtIRQ is high from edge k+3.
//  Back-to-back: with another req pending, ExtIRQ reasserts 2 cycles after the ack cycle.
//  ExtIAck while not in REQ: ignored.
//  reset mid-request: ExtIRQ drops immediately (async); all pending lost.
// STRUCTURE
//  Package irq_pkg: typedef enum logic [1:0] {IDLE, REQ, GAP} irq_state_t; default N_IRQ constant.
//  Sub-module irq_prio_enc #(N, ID_W): combinational lowest-index-first encoder, outputs {any, idx}.
//  Synchronisers are generated inline; pending/ovf/mask/FSM live in ext_irq_controller.
// TESTING
//  1 Reset, mask=0xFF, edge_mode=0xFF, pulse irq_in[3] one cycle
//    -> ExtIRQ=1 on 3rd edge after sample, irq_id=3; ack 1 cycle -> ExtIRQ=0 for 1 cycle, stays 0.
//  2 Edges on ch5 and ch2 in the same cycle -> first request id=2; after ack and GAP, id=5.
//  3 Level ch1 (edge_mode[1]=0) held high across ack
//    -> ExtIRQ reasserts with id=1 after GAP; drop irq_in[1] -> no further requests.
//  4 mask=0x00, pulse ch4 -> no ExtIRQ; write mask=0x10 -> ExtIRQ with id=4 one cycle later (t+2 edges).
//  5 Two edges on ch6 before ack -> irq_ovf[6]=1; ack id=6 -> irq_ovf[6]=0, pending[6]=0.
//  6 Assert reset while ExtIRQ=1 -> ExtIRQ=0 same cycle, irq_ovf=0.
//    Release reset -> no request until a new edge.
//  Bench asserts: ExtIRQ never high two cycles after an ack; irq_id stable throughout REQ.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and defaults for the external interrupt controller slice.
package irq_pkg;

   typedef enum logic [1:0] {IDLE, REQ, GAP} irq_state_t;

   localparam int unsigned N_IRQ_DEFAULT = 8;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set and the winning index.
module irq_prio_enc #(
   parameter int unsigned N    = 8,
   parameter int unsigned ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req_i,
   output logic            any_o,
   output logic [ID_W-1:0] idx_o
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      any_o = 1'b0;
      idx_o = '0;
      for (int unsigned i = N; i > 0; i--) begin
         if (req_i[i-1]) begin
            any_o = 1'b1;
            idx_o = ID_W'(i - 1);
         end
      end
   end

endmodule

// File: rtl/ext_irq_controller.sv
// Multi-channel external interrupt controller: synchronises sources, latches edge/level requests,
// and presents the lowest-index unmasked pending channel on a single ExtIRQ/ExtIAck handshake.
module ext_irq_controller
   import irq_pkg::*;
#(
   parameter int unsigned N_IRQ       = N_IRQ_DEFAULT,
   parameter int unsigned ID_W        = $clog2(N_IRQ),
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic [N_IRQ-1:0] edge_mode,
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_wdata,
   output logic             ExtIRQ,
   output logic [ID_W-1:0]  irq_id,
   input  logic             ExtIAck,
   output logic [N_IRQ-1:0] irq_ovf
);

   logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
   logic [N_IRQ-1:0] s_d_q;
   logic [N_IRQ-1:0] pend_q, pend_d;
   logic [N_IRQ-1:0] ovf_q, ovf_d;
   logic [N_IRQ-1:0] mask_q;
   irq_state_t       state_q;
   logic             irq_q;
   logic [ID_W-1:0]  id_q;

   logic [N_IRQ-1:0] s, rise, clr, req;
   logic             ack, any_req;
   logic [ID_W-1:0]  winner;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         s_d_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
         s_d_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   // An edge arriving on the ack cycle re-arms the channel instead of being dropped.
   always_comb begin
      s      = sync_q[SYNC_STAGES-1];
      rise   = s & ~s_d_q;
      ack    = (state_q == REQ) & ExtIAck;
      clr    = ack ? (N_IRQ'(1) << id_q) : '0;
      pend_d = (edge_mode & ((pend_q & ~clr) | rise)) | (~edge_mode & s);
      ovf_d  = (ovf_q & ~clr) | (edge_mode & rise & pend_q & ~clr);
      req    = pend_q & mask_q;
   end

   irq_prio_enc #(
      .N    (N_IRQ),
      .ID_W (ID_W)
   ) u_prio (
      .req_i (req),
      .any_o (any_req),
      .idx_o (winner)
   );

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         pend_q <= '0;
         ovf_q  <= '0;
         mask_q <= '0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         if (mask_we) mask_q <= mask_wdata;
      end
   end

   // GAP forces ExtIRQ low between consecutive requests so the core always sees a fresh edge.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         irq_q   <= 1'b0;
         id_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  state_q <= REQ;
                  irq_q   <= 1'b1;
                  id_q    <= winner;
               end
            end
            REQ: begin
               if (ExtIAck) begin
                  state_q <= GAP;
                  irq_q   <= 1'b0;
               end
            end
            GAP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               irq_q   <= 1'b0;
            end
         endcase
      end
   end

   assign ExtIRQ  = irq_q;
   assign irq_id  = id_q;
   assign irq_ovf = ovf_q;

endmodule

// File: tb/tb_ext_irq_controller.sv
// Scoreboard bench for ext_irq_controller: directed scenarios then randomized traffic
// against a cycle-level behavioural model of the controller.
module tb_ext_irq_controller;

   localparam int unsigned N    = 8;
   localparam int unsigned ID_W = 3;
   localparam int unsigned SYNC = 2;

   logic          CLOCK_50 = 1'b0;
   logic          reset;
   logic [N-1:0]  irq_in;
   logic [N-1:0]  edge_mode;
   logic          mask_we;
   logic [N-1:0]  mask_wdata;
   logic          ExtIRQ;
   logic [ID_W-1:0] irq_id;
   logic          ExtIAck;
   logic [N-1:0]  irq_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   ext_irq_controller #(
      .N_IRQ       (N),
      .ID_W        (ID_W),
      .SYNC_STAGES (SYNC)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .irq_in     (irq_in),
      .edge_mode  (edge_mode),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .ExtIRQ     (ExtIRQ),
      .irq_id     (irq_id),
      .ExtIAck    (ExtIAck),
      .irq_ovf    (irq_ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a request is outstanding or not; after an ack the controller is
   // deaf for one extra cycle; raw inputs become visible SYNC edges after being sampled.
   bit              m_req;
   int unsigned     m_id;
   int unsigned     m_cool;
   logic [N-1:0]    m_pend, m_ovf, m_mask;
   logic [N-1:0]    hist[$];
   int              exp_q[$];

   task automatic model_reset();
      m_req  = 1'b0;
      m_id   = 0;
      m_cool = 0;
      m_pend = '0;
      m_ovf  = '0;
      m_mask = '0;
      hist.delete();
      for (int i = 0; i <= int'(SYNC); i++) hist.push_back('0);
      exp_q.delete();
   endtask

   task automatic model_step();
      logic [N-1:0] s, sd, clr, np, no;
      bit ack, rise;
      int win;
      s   = hist[SYNC-1];
      sd  = hist[SYNC];
      ack = m_req && (ExtIAck === 1'b1);
      clr = '0;
      if (ack) clr[m_id] = 1'b1;
      for (int i = 0; i < int'(N); i++) begin
         if (edge_mode[i]) begin
            rise  = s[i] && !sd[i];
            np[i] = rise || (m_pend[i] && !clr[i]);
            no[i] = (m_ovf[i] && !clr[i]) || (rise && m_pend[i] && !clr[i]);
         end else begin
            np[i] = s[i];
            no[i] = m_ovf[i] && !clr[i];
         end
      end
      win = -1;
      for (int i = int'(N) - 1; i >= 0; i--)
         if (m_pend[i] && m_mask[i]) win = i;
      if (m_req) begin
         if (ack) begin
            m_req  = 1'b0;
            m_cool = 1;
         end
      end else if (m_cool > 0) begin
         m_cool--;
      end else if (win >= 0) begin
         m_req = 1'b1;
         m_id  = win;
         exp_q.push_back(win);
      end
      if (mask_we) m_mask = mask_wdata;
      m_pend = np;
      m_ovf  = no;
      hist.push_front(irq_in);
      void'(hist.pop_back());
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge CLOCK_50 or posedge reset);
         if (reset) model_reset();
         else model_step();
      end
   end

   // Monitor: compares on the falling edge, well away from the DUT's active edge.
   bit              prev_irq = 1'b0;
   logic [ID_W-1:0] prev_id  = '0;
   int              ack_win  = 0;
   int              exp_id;

   initial begin
      forever begin
         @(negedge CLOCK_50);
         check("ExtIRQ", 32'(ExtIRQ), 32'(m_req));
         check("irq_id", 32'(irq_id), m_id);
         check("irq_ovf", 32'(irq_ovf), 32'(m_ovf));
         if (ExtIRQ && !prev_irq) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL grant_id: request id %0d raised, expected no request at %0t", irq_id, $time);
            end else begin
               exp_id = exp_q.pop_front();
               check("grant_id", 32'(irq_id), 32'(exp_id));
            end
         end
         if (ExtIRQ && prev_irq) check("id_stable", 32'(irq_id), 32'(prev_id));
         if (ack_win > 0) begin
            check("gap_after_ack", 32'(ExtIRQ), 32'd0);
            ack_win--;
         end
         if (ExtIRQ && ExtIAck) ack_win = 2;
         prev_irq = ExtIRQ;
         prev_id  = irq_id;
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge CLOCK_50);
         #2;
      end
   endtask

   task automatic wait_irq(input string name, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         if (ExtIRQ) ok = 1'b1;
         else step();
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: ExtIRQ still 0, expected 1 within %0d cycles", name, budget);
      end
   endtask

   task automatic ack_once();
      ExtIAck = 1'b1;
      step();
      ExtIAck = 1'b0;
   endtask

   task automatic write_mask(input logic [N-1:0] m);
      mask_we    = 1'b1;
      mask_wdata = m;
      step();
      mask_we    = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run still active, expected end of test");
      $fatal(1, "time limit reached");
   end

   initial begin
      reset      = 1'b1;
      irq_in     = '0;
      edge_mode  = '1;
      mask_we    = 1'b0;
      mask_wdata = '0;
      ExtIAck    = 1'b0;
      step(3);
      check("rst_ExtIRQ", 32'(ExtIRQ), 32'd0);
      check("rst_irq_id", 32'(irq_id), 32'd0);
      check("rst_irq_ovf", 32'(irq_ovf), 32'd0);
      reset = 1'b0;
      step();

      // 1: single edge on ch3, exact latency and one-cycle ack
      write_mask(8'hFF);
      step(2);
      irq_in[3] = 1'b1;
      step();
      irq_in[3] = 1'b0;
      step(2);
      check("t1_before_k3", 32'(ExtIRQ), 32'd0);
      step();
      check("t1_at_k3", 32'(ExtIRQ), 32'd1);
      check("t1_id", 32'(irq_id), 32'd3);
      ack_once();
      check("t1_gap", 32'(ExtIRQ), 32'd0);
      step(3);
      check("t1_stays_low", 32'(ExtIRQ), 32'd0);

      // 2: simultaneous edges on ch5 and ch2
      irq_in = 8'b0010_0100;
      step();
      irq_in = '0;
      wait_irq("t2_first", 10);
      check("t2_first_id", 32'(irq_id), 32'd2);
      ack_once();
      wait_irq("t2_second", 10);
      check("t2_second_id", 32'(irq_id), 32'd5);
      ack_once();
      step(3);

      // 3: level channel 1 held across ack, then released
      edge_mode = 8'hFD;
      irq_in[1] = 1'b1;
      wait_irq("t3_first", 10);
      check("t3_first_id", 32'(irq_id), 32'd1);
      ack_once();
      wait_irq("t3_reassert", 10);
      check("t3_reassert_id", 32'(irq_id), 32'd1);
      irq_in[1] = 1'b0;
      step(4);
      check("t3_not_retracted", 32'(ExtIRQ), 32'd1);
      ack_once();
      step(6);
      check("t3_quiet", 32'(ExtIRQ), 32'd0);
      edge_mode = 8'hFF;

      // 4: masked capture, released by a later mask write
      write_mask(8'h00);
      irq_in[4] = 1'b1;
      step();
      irq_in[4] = 1'b0;
      step(6);
      check("t4_masked", 32'(ExtIRQ), 32'd0);
      write_mask(8'h10);
      check("t4_mask_edge", 32'(ExtIRQ), 32'd0);
      step();
      check("t4_unmasked", 32'(ExtIRQ), 32'd1);
      check("t4_id", 32'(irq_id), 32'd4);
      ack_once();
      write_mask(8'hFF);
      step(3);

      // 5: second edge on ch6 while pending
      irq_in[6] = 1'b1; step();
      irq_in[6] = 1'b0; step();
      irq_in[6] = 1'b1; step();
      irq_in[6] = 1'b0; step(4);
      check("t5_req", 32'(ExtIRQ), 32'd1);
      check("t5_id", 32'(irq_id), 32'd6);
      check("t5_ovf", 32'(irq_ovf), 32'h40);
      ack_once();
      check("t5_ovf_clr", 32'(irq_ovf), 32'd0);
      step(4);
      check("t5_pend_clr", 32'(ExtIRQ), 32'd0);

      // 6: reset while requesting with an overflow recorded
      irq_in[0] = 1'b1; step();
      irq_in[0] = 1'b0; step();
      irq_in[0] = 1'b1; step();
      irq_in[0] = 1'b0;
      wait_irq("t6_req", 10);
      step(3);
      reset = 1'b1;
      #1;
      check("t6_rst_irq", 32'(ExtIRQ), 32'd0);
      check("t6_rst_ovf", 32'(irq_ovf), 32'd0);
      step(2);
      reset = 1'b0;
      write_mask(8'hFF);
      step(8);
      check("t6_no_req", 32'(ExtIRQ), 32'd0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         irq_in    ^= N'($urandom & $urandom & $urandom);
         if ($urandom_range(199) == 0) edge_mode = N'($urandom);
         mask_we    = ($urandom_range(19) == 0);
         mask_wdata = N'($urandom | $urandom);
         ExtIAck    = ($urandom_range(99) < 35);
         reset      = ($urandom_range(499) == 0);
         step();
      end
      reset   = 1'b0;
      mask_we = 1'b0;
      irq_in  = '0;
      ExtIAck = 1'b1;
      step(60);
      ExtIAck = 1'b0;
      step(2);
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
